corescore_reset_seq: RTL and testbench
======================================

Name: corescore_reset_seq

Overview:
- Parametrised reset sequencer for the PLL-generated clock domain. Runs entirely on o_clk.
- Synchronises and debounces the PLL lock signal, holds reset for a minimum time after lock, then releases NUM_RST reset channels one after another (channel 0 first).
- Re-asserts all channels when lock is lost, and reports lock-loss status. Sits between the PLL instance and the SoC/core-array reset inputs.

Parameters:
- SYNC_STAGES, 2: flops in the i_locked synchroniser; must be >=2.
- LOCK_FILTER, 4: consecutive synchronised-high samples needed to accept lock; >=1.
- HOLD_CYCLES, 16: cycles all resets stay asserted after lock is accepted; >=1.
- STAGE_GAP, 4: cycles between deassertion of consecutive channels; >=1.
- NUM_RST, 2: number of reset output channels; >=1.

Ports:
- o_clk  input  1  generated PLL clock; all logic is in this domain.
- i_rst  input  1  reset; synchronous, active-high.
- i_locked  input  1  PLL lock, asynchronous to o_clk.
- o_rst  output  NUM_RST  per-channel active-high reset; registered.
- o_ready  output  1  high once every channel is released; registered.
- o_lock_lost  output  1  sticky flag: lock was lost after being accepted.
- o_relock_cnt  output  8  number of lock-loss events, saturating.

Behaviour:
- Clock and reset: clock is o_clk; reset i_rst is synchronous and active-high. On any edge with i_rst=1:
  - o_rst all ones, o_ready=0, o_lock_lost=0, o_relock_cnt=0.
  - Synchroniser flops 0, filter and sequence counters 0, state WAIT_LOCK.
  - i_rst asserted mid-sequence or in RUN behaves identically; no partial state survives.
- Synchroniser: SYNC_STAGES-flop chain gives lk_s. Edge numbering: edge 1 is the first edge that samples the new i_locked value. lk_s changes after edge SYNC_STAGES.
- Lock filter (registered lock_ok):
  - Counter increments while lk_s=1, saturating at LOCK_FILTER.
  - lock_ok=1 once the counter reaches LOCK_FILTER, i.e. after edge SYNC_STAGES+LOCK_FILTER for a clean rise.
  - Any lk_s=0 sample clears the counter and lock_ok at that edge (edge SYNC_STAGES+1 after a fall). Loss is not filtered.
- States: WAIT_LOCK, HOLD, RELEASE, RUN. One shared down-counter of width clog2(max(HOLD_CYCLES,STAGE_GAP)+1); stage index of width clog2(NUM_RST+1).
  - WAIT_LOCK: all o_rst=1. Let E0 be the edge where lock_ok first reads 1. The state moves to HOLD on the edge after E0.
  - HOLD: all o_rst=1; runs out HOLD_CYCLES.
  - RELEASE: sequences the channel deassertions. Outputs are measured from E0:
    - o_rst[k] goes low at edge E0+HOLD_CYCLES+k*STAGE_GAP.
    - Channels already released stay low.
    - After the last channel is released, the state becomes RUN.
  - RUN: o_rst all 0. o_ready=1 from the same edge o_rst[NUM_RST-1] goes low.
- Lock loss (lock_ok=0 while in HOLD, RELEASE or RUN):
  - On the next edge: all o_rst=1, o_ready=0, o_lock_lost=1, o_relock_cnt += 1 (saturates at 255), state WAIT_LOCK.
  - A full sequence (filter, hold, staged release) restarts when lock returns.
  - Lock loss in WAIT_LOCK is not counted.
- Simultaneous lock loss and stage release in the same cycle: lock loss wins; no channel deasserts.
- NUM_RST=1: o_ready rises with o_rst[0]; STAGE_GAP is unused.
- o_rst never deasserts out of order. No output deasserts while lock_ok=0.

Decomposition:
- Shared package/include holds the state encoding localparams (WAIT_LOCK=0, HOLD=1, RELEASE=2, RUN=3) and the saturating relock-count width (8).
- One sub-module, corescore_lock_filter: synchroniser plus debounce counter. Inputs o_clk, i_rst, i_locked; output lock_ok. Parameters SYNC_STAGES and LOCK_FILTER.
- The FSM, counters and output registers stay in corescore_reset_seq.

Test Plan:
All scenarios use defaults with NUM_RST=3, so E0 = edge 6 for a clean rise.
1. i_rst pulse, then i_locked=1 from edge 1:
   - o_rst[0] low at edge 22, o_rst[1] at 26, o_rst[2] at 30.
   - o_ready=1 at 30; all o_rst=111 before 22.
2. i_locked glitches low for 1 cycle during HOLD (edge 12):
   - o_relock_cnt=1, o_lock_lost=1.
   - Sequence restarts: new E0 counted from the rise; first release 16 cycles after the new E0.
3. i_locked toggles high 3 cycles, low 1, repeatedly:
   - lock_ok never asserts; o_rst stays 111, o_ready=0, o_relock_cnt=0.
4. In RUN, i_locked drops at edge 100:
   - o_rst=111 and o_ready=0 at edge 104 (SYNC_STAGES+2); o_relock_cnt increments to 1.
5. i_rst asserted in RELEASE right after o_rst[0] releases:
   - Next edge o_rst=111, o_lock_lost=0, o_relock_cnt=0; full sequence repeats from edge 1.
6. 300 lock-loss events:
   - o_relock_cnt saturates at 255; o_lock_lost stays 1 until i_rst.

Source files
------------

// File: rtl/corescore_reset_seq_pkg.sv
// Shared definitions for the PLL-domain reset sequencer: state encoding,
// relock counter width and a small elaboration-time helper.
package corescore_reset_seq_pkg;

  localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
  localparam logic [1:0] ST_HOLD      = 2'd1;
  localparam logic [1:0] ST_RELEASE   = 2'd2;
  localparam logic [1:0] ST_RUN       = 2'd3;

  localparam int unsigned RELOCK_W = 8;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/corescore_lock_filter.sv
// Synchronises the asynchronous PLL lock into o_clk and requires LOCK_FILTER
// consecutive high samples before reporting lock; any low sample drops it at once.
module corescore_lock_filter
  import corescore_reset_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_FILTER = 4
) (
  input  logic o_clk,
  input  logic i_rst,
  input  logic i_locked,
  output logic lock_ok
);

  localparam int unsigned FW = $clog2(LOCK_FILTER + 1);
  localparam logic [FW-1:0] FMAX    = FW'(LOCK_FILTER);
  localparam logic [FW-1:0] FMAX_M1 = FW'(LOCK_FILTER - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [FW-1:0]          cnt_q, cnt_d;
  logic                   lock_q, lock_d;
  logic                   lk_s;

  assign lk_s    = sync_q[SYNC_STAGES-1];
  assign lock_ok = lock_q;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_locked};
    cnt_d  = '0;
    lock_d = 1'b0;
    if (lk_s) begin
      cnt_d  = (cnt_q == FMAX) ? cnt_q : cnt_q + 1'b1;
      // Lock is declared on the same edge the counter reaches LOCK_FILTER.
      lock_d = (cnt_q >= FMAX_M1);
    end
  end

  always_ff @(posedge o_clk) begin
    if (i_rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      lock_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      lock_q <= lock_d;
    end
  end

endmodule

// File: rtl/corescore_reset_seq.sv
// Reset sequencer: holds all channels in reset until lock is stable for
// HOLD_CYCLES, then releases them in order; lock loss re-asserts everything.
module corescore_reset_seq
  import corescore_reset_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_FILTER = 4,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned STAGE_GAP   = 4,
  parameter int unsigned NUM_RST     = 2
) (
  input  logic                o_clk,
  input  logic                i_rst,
  input  logic                i_locked,
  output logic [NUM_RST-1:0]  o_rst,
  output logic                o_ready,
  output logic                o_lock_lost,
  output logic [RELOCK_W-1:0] o_relock_cnt
);

  localparam int unsigned CW = $clog2(max_u(HOLD_CYCLES, STAGE_GAP) + 1);
  localparam int unsigned SW = $clog2(NUM_RST + 1);
  // The WAIT_LOCK->HOLD edge already consumes one hold cycle, so HOLD loads two less.
  localparam logic [CW-1:0] HOLD_LOAD = CW'((HOLD_CYCLES >= 2) ? HOLD_CYCLES - 2 : 0);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(STAGE_GAP - 1);
  localparam logic [SW-1:0] LAST_STG  = SW'(NUM_RST - 1);

  logic                lock_ok;
  logic [1:0]          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [SW-1:0]       stage_q, stage_d;
  logic [NUM_RST-1:0]  rst_q, rst_d;
  logic                ready_q, ready_d;
  logic                lost_q, lost_d;
  logic [RELOCK_W-1:0] relock_q, relock_d;
  logic                loss, rel_now;

  corescore_lock_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .LOCK_FILTER (LOCK_FILTER)
  ) u_lock_filter (
    .o_clk    (o_clk),
    .i_rst    (i_rst),
    .i_locked (i_locked),
    .lock_ok  (lock_ok)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stage_d  = stage_q;
    rst_d    = rst_q;
    ready_d  = ready_q;
    lost_d   = lost_q;
    relock_d = relock_q;
    loss     = 1'b0;
    rel_now  = 1'b0;

    case (state_q)
      ST_WAIT_LOCK: begin
        if (lock_ok) begin
          if (HOLD_CYCLES == 1) begin
            rel_now = 1'b1;
          end else begin
            state_d = ST_HOLD;
            cnt_d   = HOLD_LOAD;
          end
        end
      end
      ST_HOLD, ST_RELEASE: begin
        if (!lock_ok)           loss = 1'b1;
        else if (cnt_q == '0)   rel_now = 1'b1;
        else                    cnt_d = cnt_q - 1'b1;
      end
      default: begin
        if (!lock_ok) loss = 1'b1;
      end
    endcase

    if (rel_now) begin
      for (int unsigned k = 0; k < NUM_RST; k++) begin
        if (SW'(k) == stage_q) rst_d[k] = 1'b0;
      end
      stage_d = stage_q + 1'b1;
      if (stage_q == LAST_STG) begin
        state_d = ST_RUN;
        ready_d = 1'b1;
      end else begin
        state_d = ST_RELEASE;
        cnt_d   = GAP_LOAD;
      end
    end

    // Loss overrides any release decided in the same cycle.
    if (loss) begin
      state_d  = ST_WAIT_LOCK;
      cnt_d    = '0;
      stage_d  = '0;
      rst_d    = '1;
      ready_d  = 1'b0;
      lost_d   = 1'b1;
      relock_d = (relock_q == '1) ? relock_q : relock_q + 1'b1;
    end
  end

  always_ff @(posedge o_clk) begin
    if (i_rst) begin
      state_q  <= ST_WAIT_LOCK;
      cnt_q    <= '0;
      stage_q  <= '0;
      rst_q    <= '1;
      ready_q  <= 1'b0;
      lost_q   <= 1'b0;
      relock_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stage_q  <= stage_d;
      rst_q    <= rst_d;
      ready_q  <= ready_d;
      lost_q   <= lost_d;
      relock_q <= relock_d;
    end
  end

  assign o_rst        = rst_q;
  assign o_ready      = ready_q;
  assign o_lock_lost  = lost_q;
  assign o_relock_cnt = relock_q;

endmodule

// File: tb/tb_corescore_reset_seq.sv
// Bench for corescore_reset_seq with NUM_RST=3: scenario tasks plus a
// timeline reference model (lock window over raw samples, release times from E0).
`timescale 1ns/1ps
module tb_corescore_reset_seq;

  localparam int S = 2;
  localparam int F = 4;
  localparam int H = 16;
  localparam int G = 4;
  localparam int N = 3;

  logic         o_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_locked = 1'b0;
  logic [N-1:0] o_rst;
  logic         o_ready;
  logic         o_lock_lost;
  logic [7:0]   o_relock_cnt;

  int vectors = 0;
  int miscompares = 0;

  corescore_reset_seq #(
    .SYNC_STAGES (S),
    .LOCK_FILTER (F),
    .HOLD_CYCLES (H),
    .STAGE_GAP   (G),
    .NUM_RST     (N)
  ) dut (
    .o_clk        (o_clk),
    .i_rst        (i_rst),
    .i_locked     (i_locked),
    .o_rst        (o_rst),
    .o_ready      (o_ready),
    .o_lock_lost  (o_lock_lost),
    .o_relock_cnt (o_relock_cnt)
  );

  always #5 o_clk = ~o_clk;

  // Reference model: lock is accepted when the F raw samples taken S..S+F-1
  // edges ago were all high (samples at or before a reset count as low);
  // channel k is released at E0+H+k*G while lock holds.
  bit           hist[S+F];
  int           ecnt = 0;
  int           e0 = 0;
  bit           active = 0;
  bit           lok;
  logic [N-1:0] m_rst = '1;
  logic         m_ready = 0;
  logic         m_lost = 0;
  int           m_cnt = 0;
  logic [12:0]  mod_v;
  logic [12:0]  dut_v;

  assign dut_v = {o_rst, o_ready, o_lock_lost, o_relock_cnt};

  always @(posedge o_clk) begin
    ecnt++;
    if (i_rst) begin
      for (int i = 0; i < S + F; i++) hist[i] = 1'b0;
      active = 0;
      m_lost = 0;
      m_cnt  = 0;
    end else begin
      lok = 1;
      for (int i = S; i < S + F; i++) if (!hist[i]) lok = 0;
      for (int i = S + F - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = i_locked;
      if (!active) begin
        if (lok) begin
          active = 1;
          e0 = ecnt - 1;
        end
      end else if (!lok) begin
        active = 0;
        m_lost = 1;
        if (m_cnt < 255) m_cnt++;
      end
    end
    m_rst   = '1;
    m_ready = 0;
    if (active) begin
      for (int k = 0; k < N; k++) m_rst[k] = (ecnt < e0 + H + k * G);
      m_ready = (ecnt >= e0 + H + (N - 1) * G);
    end
    mod_v = {m_rst, m_ready, m_lost, 8'(m_cnt)};
  end

  task automatic tick();
    @(posedge o_clk);
    @(negedge o_clk);
  endtask

  task automatic apply_reset(input logic lock_after);
    i_rst = 1'b1;
    i_locked = 1'b0;
    tick();
    i_rst = 1'b0;
    i_locked = lock_after;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_locked = 1'($urandom_range(0, 1));
    tick();
    tick();
    vectors++;
    if (dut_v !== {3'b111, 1'b0, 1'b0, 8'd0}) begin
      miscompares++;
      $display("FAIL reset_state: got=%h want=%h", dut_v, {3'b111, 1'b0, 1'b0, 8'd0});
    end
    vectors++;
    if (dut_v !== mod_v) begin
      miscompares++;
      $display("FAIL reset_model: got=%h want=%h", dut_v, mod_v);
    end
    i_rst = 1'b0;
    i_locked = 1'b0;
  endtask

  task automatic test_release();
    apply_reset(1'b1);
    for (int k = 1; k <= 34; k++) begin
      tick();
      vectors++;
      if (dut_v !== mod_v) begin
        miscompares++;
        $display("FAIL release edge %0d: got=%h want=%h", k, dut_v, mod_v);
      end
      if (k == 21 || k == 22 || k == 26 || k == 29 || k == 30) begin
        logic [3:0] want;
        want = (k == 21) ? 4'b1110 : (k == 22) ? 4'b1100 :
               (k == 26 || k == 29) ? 4'b1000 : 4'b0001;
        vectors++;
        if ({o_rst, o_ready} !== want) begin
          miscompares++;
          $display("FAIL release_timing edge %0d: rst,ready got=%b want=%b", k, {o_rst, o_ready}, want);
        end
      end
    end
  endtask

  task automatic test_hold_glitch();
    apply_reset(1'b1);
    for (int k = 1; k <= 45; k++) begin
      i_locked = (k != 12);
      tick();
      vectors++;
      if (dut_v !== mod_v) begin
        miscompares++;
        $display("FAIL hold_glitch edge %0d: got=%h want=%h", k, dut_v, mod_v);
      end
      if (k == 14 || k == 15 || k == 33 || k == 34) begin
        logic [12:0] want;
        want = (k == 14) ? {3'b111, 1'b0, 1'b0, 8'd0} :
               (k == 34) ? {3'b110, 1'b0, 1'b1, 8'd1} : {3'b111, 1'b0, 1'b1, 8'd1};
        vectors++;
        if (dut_v !== want) begin
          miscompares++;
          $display("FAIL hold_glitch_fixed edge %0d: got=%h want=%h", k, dut_v, want);
        end
      end
    end
  endtask

  task automatic test_toggle();
    apply_reset(1'b0);
    for (int k = 1; k <= 64; k++) begin
      i_locked = ((k % 4) != 0);
      tick();
      vectors++;
      if (dut_v !== {3'b111, 1'b0, 1'b0, 8'd0} || dut_v !== mod_v) begin
        miscompares++;
        $display("FAIL toggle edge %0d: got=%h want=%h", k, dut_v, {3'b111, 1'b0, 1'b0, 8'd0});
      end
    end
  endtask

  task automatic test_run_loss();
    apply_reset(1'b1);
    for (int k = 1; k <= 110; k++) begin
      i_locked = (k <= 100);
      tick();
      vectors++;
      if (dut_v !== mod_v) begin
        miscompares++;
        $display("FAIL run_loss edge %0d: got=%h want=%h", k, dut_v, mod_v);
      end
      if (k == 103 || k == 104) begin
        logic [12:0] want;
        want = (k == 103) ? {3'b000, 1'b1, 1'b0, 8'd0} : {3'b111, 1'b0, 1'b1, 8'd1};
        vectors++;
        if (dut_v !== want) begin
          miscompares++;
          $display("FAIL run_loss_fixed edge %0d: got=%h want=%h", k, dut_v, want);
        end
      end
    end
  endtask

  task automatic test_rst_in_release();
    apply_reset(1'b1);
    for (int k = 1; k <= 34; k++) begin
      i_locked = (k != 12);
      tick();
    end
    vectors++;
    if (dut_v !== {3'b110, 1'b0, 1'b1, 8'd1}) begin
      miscompares++;
      $display("FAIL rst_rel_pre: got=%h want=%h", dut_v, {3'b110, 1'b0, 1'b1, 8'd1});
    end
    i_rst = 1'b1;
    tick();
    vectors++;
    if (dut_v !== {3'b111, 1'b0, 1'b0, 8'd0} || dut_v !== mod_v) begin
      miscompares++;
      $display("FAIL rst_rel_clear: got=%h want=%h", dut_v, {3'b111, 1'b0, 1'b0, 8'd0});
    end
    i_rst = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      vectors++;
      if (dut_v !== mod_v) begin
        miscompares++;
        $display("FAIL rst_rel_again edge %0d: got=%h want=%h", k, dut_v, mod_v);
      end
      if (k == 21 || k == 22) begin
        vectors++;
        if (o_rst !== ((k == 21) ? 3'b111 : 3'b110)) begin
          miscompares++;
          $display("FAIL rst_rel_timing edge %0d: got=%b want=%b", k, o_rst, (k == 21) ? 3'b111 : 3'b110);
        end
      end
    end
  endtask

  task automatic test_saturation();
    apply_reset(1'b0);
    for (int ev = 0; ev < 300; ev++) begin
      int hi, lo;
      hi = $urandom_range(5, 8);
      lo = $urandom_range(1, 4);
      for (int c = 0; c < hi + lo; c++) begin
        i_locked = (c < hi);
        tick();
        vectors++;
        if (dut_v !== mod_v) begin
          miscompares++;
          $display("FAIL saturation ev %0d: got=%h want=%h", ev, dut_v, mod_v);
        end
      end
    end
    i_locked = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    vectors++;
    if (o_relock_cnt !== 8'd255 || o_lock_lost !== 1'b1) begin
      miscompares++;
      $display("FAIL saturation_end: cnt=%0d lost=%b want cnt=255 lost=1", o_relock_cnt, o_lock_lost);
    end
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    vectors++;
    if (o_relock_cnt !== 8'd0 || o_lock_lost !== 1'b0) begin
      miscompares++;
      $display("FAIL saturation_clear: cnt=%0d lost=%b want cnt=0 lost=0", o_relock_cnt, o_lock_lost);
    end
  endtask

  task automatic test_random();
    int run;
    run = 0;
    apply_reset(1'b0);
    for (int k = 0; k < 1500; k++) begin
      if (run == 0) begin
        i_locked = ~i_locked;
        run = (i_locked) ? $urandom_range(1, 40) : $urandom_range(1, 6);
      end
      run--;
      i_rst = ($urandom_range(0, 199) == 0);
      tick();
      vectors++;
      if (dut_v !== mod_v) begin
        miscompares++;
        $display("FAIL random cycle %0d: got=%h want=%h", k, dut_v, mod_v);
      end
    end
    i_rst = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_release();
    test_hold_glitch();
    test_toggle();
    test_run_loss();
    test_rst_in_release();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
